count_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one bit-population counter (count_W8 family) between N requesters.
- Each requester supplies a W-bit word and a count mode (ones or zeros).
- The arbiter grants one requester, launches the counter with a start pulse and holds its inputs stable until done.
- It returns the count to the granted requester and protects against a hung counter with a watchdog.

---
 rtl/count_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_count_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_arbiter.sv
// Round-robin front end that shares one bit-population counter between N requesters.
// Selects a requester, launches the counter, holds its operands until done,
// returns the count to the granted requester and aborts hung operations with a watchdog.
module count_arbiter #(
  parameter int unsigned W   = 8,
  parameter int unsigned N   = 4,
  parameter int unsigned TMO = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  input  logic [2*N-1:0] req_sel,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_cnt,
  output logic           rsp_err,
  output logic           busy,
  output logic           cnt_start,
  output logic [W-1:0]   cnt_a_in,
  output logic [1:0]     cnt_sel,
  input  logic           cnt_done,
  input  logic [W-1:0]   cnt_cntout
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = $clog2(TMO + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam logic [IW-1:0] LastIdx  = IW'(N - 1);
  localparam logic [TW-1:0] WdogLast = TW'(TMO - 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_cnt_q, rsp_cnt_d;
  logic          rsp_err_q, rsp_err_d;
  logic          busy_q, busy_d;
  logic          cnt_start_q, cnt_start_d;
  logic [W-1:0]  cnt_a_in_q, cnt_a_in_d;
  logic [1:0]    cnt_sel_q, cnt_sel_d;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic [W-1:0]  pick_data;
  logic [1:0]    pick_sel;
  logic          pick_legal;
  logic [N-1:0]  pick_oh;
  logic [N-1:0]  idx_oh;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LastIdx) ? '0 : i + 1'b1;
  endfunction

  // Round-robin search: first set request starting at ptr, wrapping mod N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < int'(N); i++) begin
      cand = IW'((int'(ptr_q) + i) % int'(N));
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Operand mux for the selected requester.
  always_comb begin
    pick_data = '0;
    pick_sel  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (pick == IW'(i)) begin
        pick_data = req_data[i*W +: W];
        pick_sel  = req_sel[i*2 +: 2];
      end
    end
  end

  assign pick_legal = (pick_sel == 2'b10) || (pick_sel == 2'b01);
  assign pick_oh    = {{(N-1){1'b0}}, 1'b1} << pick;
  assign idx_oh     = {{(N-1){1'b0}}, 1'b1} << idx_q;

  // Sequencer next state; pulses default low, counter operands hold unless changed.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    wdog_d      = wdog_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_cnt_d   = '0;
    rsp_err_d   = 1'b0;
    cnt_start_d = 1'b0;
    cnt_a_in_d  = cnt_a_in_q;
    cnt_sel_d   = cnt_sel_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          idx_d = pick;
          if (pick_legal) begin
            state_d     = StIssue;
            gnt_d       = pick_oh;
            cnt_start_d = 1'b1;
            cnt_a_in_d  = pick_data;
            cnt_sel_d   = pick_sel;
          end else begin
            // Illegal mode: answer with an error without touching the counter.
            state_d     = StResp;
            rsp_valid_d = pick_oh;
            rsp_err_d   = 1'b1;
            ptr_d       = next_idx(pick);
          end
        end
      end
      StIssue: begin
        // A done arriving together with start belongs to no operation of ours.
        ptr_d   = next_idx(idx_q);
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        wdog_d = wdog_q + 1'b1;
        if (cnt_done) begin
          state_d     = StResp;
          rsp_valid_d = idx_oh;
          rsp_cnt_d   = cnt_cntout;
          cnt_a_in_d  = '0;
          cnt_sel_d   = '0;
        end else if (wdog_q == WdogLast) begin
          state_d     = StResp;
          rsp_valid_d = idx_oh;
          rsp_err_d   = 1'b1;
          cnt_a_in_d  = '0;
          cnt_sel_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      idx_q       <= '0;
      wdog_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_cnt_q   <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cnt_start_q <= 1'b0;
      cnt_a_in_q  <= '0;
      cnt_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      wdog_q      <= wdog_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_cnt_q   <= rsp_cnt_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      cnt_start_q <= cnt_start_d;
      cnt_a_in_q  <= cnt_a_in_d;
      cnt_sel_q   <= cnt_sel_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_cnt   = rsp_cnt_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign cnt_start = cnt_start_q;
  assign cnt_a_in  = cnt_a_in_q;
  assign cnt_sel   = cnt_sel_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Scoreboard bench for count_arbiter: a reference model predicts service order and
// results when requests are raised; a monitor checks every grant and response.
module tb_count_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [2*N-1:0] req_sel = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_cnt;
  logic           rsp_err;
  logic           busy;
  logic           cnt_start;
  logic [W-1:0]   cnt_a_in;
  logic [1:0]     cnt_sel;
  logic           cnt_done = 1'b0;
  logic [W-1:0]   cnt_cntout = '0;

  count_arbiter #(.W(W), .N(N), .TMO(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_sel    (req_sel),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_cnt    (rsp_cnt),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .cnt_start  (cnt_start),
    .cnt_a_in   (cnt_a_in),
    .cnt_sel    (cnt_sel),
    .cnt_done   (cnt_done),
    .cnt_cntout (cnt_cntout)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [W-1:0] data;
    logic [1:0] sel;
    logic [W-1:0] cnt;
    bit         err;
    bit         legal;
  } exp_t;

  exp_t gnt_exp[$];
  exp_t rsp_exp[$];

  int checks = 0;
  int failures = 0;
  int ptr_m = 0;
  int cyc = 0;
  bit hang = 1'b0;
  bit inflight = 1'b0;
  bit idle_next = 1'b0;
  int gnt_cyc = 0;
  logic [W-1:0] cur_data = '0;
  logic [1:0] cur_sel = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=completion cycle=%0d", name, cyc);
  endtask

  function automatic logic [W-1:0] ref_count(input logic [W-1:0] d, input logic [1:0] s);
    if (s == 2'b10) return W'($countones(d));
    if (s == 2'b01) return W'(W - $countones(d));
    return '0;
  endfunction

  // Predict the order and results for requests drawn from mask: round robin from ptr_m.
  function automatic void model_push(input logic [N-1:0] mask, input int n, input bit drop);
    logic [N-1:0] s;
    exp_t e;
    int c;
    bit hit;
    s = mask;
    for (int k = 0; k < n; k++) begin
      hit = 1'b0;
      c = 0;
      for (int o = 0; o < N; o++) begin
        if (!hit && s[(ptr_m + o) % N]) begin
          hit = 1'b1;
          c = (ptr_m + o) % N;
        end
      end
      if (!hit) break;
      e.idx   = c;
      e.data  = req_data[c*W +: W];
      e.sel   = req_sel[c*2 +: 2];
      e.legal = (e.sel == 2'b10) || (e.sel == 2'b01);
      e.err   = !e.legal || hang;
      e.cnt   = e.err ? '0 : ref_count(e.data, e.sel);
      rsp_exp.push_back(e);
      if (e.legal) gnt_exp.push_back(e);
      ptr_m = (c + 1) % N;
      if (drop) s[c] = 1'b0;
    end
  endfunction

  // Counter model: done after a random delay, garbage result otherwise, spurious done on start.
  initial begin : counter_model
    logic [W-1:0] cm_a;
    logic [1:0] cm_sel;
    bit cm_pend;
    int cm_wait;
    cm_a = '0; cm_sel = '0; cm_pend = 1'b0; cm_wait = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cm_pend = 1'b0;
        cnt_done = 1'b0;
        cnt_cntout = '0;
      end else begin
        cnt_done = 1'b0;
        cnt_cntout = W'($urandom);
        if (cnt_start) begin
          cm_a = cnt_a_in;
          cm_sel = cnt_sel;
          cm_pend = !hang;
          cm_wait = $urandom_range(0, 4);
          if ($urandom_range(0, 3) == 0) cnt_done = 1'b1;
        end else if (cm_pend) begin
          if (cm_wait == 0) begin
            cnt_done = 1'b1;
            cnt_cntout = ref_count(cm_a, cm_sel);
            cm_pend = 1'b0;
          end else begin
            cm_wait--;
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant or response.
  initial begin : monitor
    exp_t e;
    exp_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        check("start_with_gnt", 32'(cnt_start), 32'(gnt != '0));
        if (gnt != '0) begin
          if (gnt_exp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_gnt actual=0x%0h expected=none cycle=%0d", gnt, cyc);
          end else begin
            e = gnt_exp.pop_front();
            check("gnt_onehot", 32'(gnt), 32'(1) << e.idx);
            check("gnt_a_in", 32'(cnt_a_in), 32'(e.data));
            check("gnt_sel", 32'(cnt_sel), 32'(e.sel));
            check("busy_at_gnt", 32'(busy), 32'(1));
            inflight = 1'b1;
            cur_data = e.data;
            cur_sel = e.sel;
            gnt_cyc = cyc;
          end
        end else if (inflight && rsp_valid == '0) begin
          check("hold_a_in", 32'(cnt_a_in), 32'(cur_data));
          check("hold_sel", 32'(cnt_sel), 32'(cur_sel));
        end
        if (rsp_valid != '0) begin
          if (rsp_exp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp actual=0x%0h expected=none cycle=%0d", rsp_valid, cyc);
          end else begin
            r = rsp_exp.pop_front();
            check("rsp_onehot", 32'(rsp_valid), 32'(1) << r.idx);
            check("rsp_cnt", 32'(rsp_cnt), 32'(r.cnt));
            check("rsp_err", 32'(rsp_err), 32'(r.err));
            check("rsp_clears_cnt_in", 32'({cnt_a_in, cnt_sel}), 32'(0));
            if (r.legal && r.err) check("wdog_latency", 32'(cyc - gnt_cyc), 32'(TMO + 1));
          end
          inflight = 1'b0;
          idle_next = 1'b1;
        end else if (idle_next) begin
          check("busy_falls", 32'(busy), 32'(0));
          idle_next = 1'b0;
        end
        if (!busy) check("idle_quiet", 32'({gnt, rsp_valid, cnt_start, cnt_a_in, cnt_sel}), 32'(0));
      end
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] d, input logic [1:0] s);
    req_data[i*W +: W] = d;
    req_sel[i*2 +: 2] = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("reset_outputs", 32'({gnt, rsp_valid, rsp_cnt, rsp_err, busy, cnt_start, cnt_a_in,
                                cnt_sel}), 32'(0));
    gnt_exp.delete();
    rsp_exp.delete();
    ptr_m = 0;
    inflight = 1'b0;
    idle_next = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((rsp_exp.size() != 0 || busy) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) fail_now("wait_idle");
  endtask

  // Raise mask together; each requester drops on its grant (or its illegal response).
  task automatic run_batch(input logic [N-1:0] mask, input bit chk_fast);
    int guard;
    guard = 0;
    model_push(mask, $countones(mask), 1'b1);
    req = mask;
    do begin
      @(negedge clk);
      guard++;
      if (guard == 1 && chk_fast) begin
        check("illegal_fast_rsp", 32'(rsp_valid), 32'(mask));
        check("illegal_no_gnt", 32'({gnt, cnt_start}), 32'(0));
      end
      for (int i = 0; i < N; i++) begin
        if (req[i] && (gnt[i] || rsp_valid[i])) begin
          req[i] = 1'b0;
          req_data[i*W +: W] = W'($urandom);
        end
      end
    end while ((req != '0 || rsp_exp.size() != 0 || busy) && guard < 2000);
    if (guard >= 2000) fail_now("batch_done");
  endtask

  // Hold mask high until n grants have been issued.
  task automatic run_held(input logic [N-1:0] mask, input int n);
    int guard;
    int seen;
    guard = 0;
    seen = 0;
    model_push(mask, n, 1'b0);
    req = mask;
    while (seen < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (gnt != '0) seen++;
    end
    if (guard >= 2000) fail_now("held_grants");
  endtask

  initial begin : stimulus
    int guard;
    logic [N-1:0] mask;
    int r;
    do_reset();

    set_req(0, 8'h0B, 2'b10);
    run_batch(4'b0001, 1'b0);
    set_req(1, 8'h04, 2'b01);
    run_batch(4'b0010, 1'b0);

    do_reset();
    set_req(0, 8'hA5, 2'b10);
    set_req(1, 8'h3C, 2'b01);
    set_req(2, 8'hF0, 2'b10);
    set_req(3, 8'h81, 2'b01);
    run_held(4'b1111, 5);
    run_held(4'b0101, 4);
    req = '0;
    wait_idle();

    set_req(3, 8'h5A, 2'b11);
    run_batch(4'b1000, 1'b1);
    set_req(0, 8'h77, 2'b10);
    set_req(1, 8'h12, 2'b01);
    run_batch(4'b0011, 1'b0);

    hang = 1'b1;
    set_req(1, 8'h33, 2'b10);
    run_batch(4'b0010, 1'b0);
    hang = 1'b0;
    set_req(2, 8'hFF, 2'b10);
    run_batch(4'b0100, 1'b0);

    // Reset in the middle of a wait: response is dropped and the pointer returns to 0.
    hang = 1'b1;
    set_req(1, 8'h0F, 2'b10);
    model_push(4'b0010, 1, 1'b1);
    req = 4'b0010;
    guard = 0;
    while (gnt == '0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) fail_now("gnt_before_reset");
    req = '0;
    repeat (5) @(negedge clk);
    do_reset();
    hang = 1'b0;
    set_req(0, 8'hC3, 2'b10);
    set_req(2, 8'h01, 2'b01);
    run_batch(4'b0101, 1'b0);

    for (int t = 0; t < 40; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 9);
        set_req(i, W'($urandom), (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b10 : 2'b01);
      end
      hang = ($urandom_range(0, 9) == 0);
      run_batch(mask, 1'b0);
      hang = 1'b0;
    end

    check("scoreboard_drained", 32'(rsp_exp.size() + gnt_exp.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : time_limit
    #1000000;
    $display("FAIL time_limit actual=running expected=finished cycle=%0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
